// File: rtl/md_unit_iter_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// start is taken only while busy=0 and req=0; busy=1 means the unit ignores start/mthi/mtlo and the hazard unit must stall.
interface md_unit_iter_if #(parameter int WIDTH = 32);
    logic             req;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (output req, start, op, a, b, input hi, lo, out, busy);
    modport slave  (input req, start, op, a, b, output hi, lo, out, busy);
endinterface

// File: rtl/md_unit_iter.sv
// Iterative radix-2 multiply / restoring divide with HI/LO accumulate (madd/msub) support.
// One bit per cycle: WIDTH calc cycles plus one fix-up cycle per operation.
module md_unit_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_iter_if.slave bus,
    output logic [1:0]    state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;
    localparam logic [3:0] OP_MFHI  = 4'd11;
    localparam logic [3:0] OP_MFLO  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;    // product, or {remainder, quotient}
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic [1:0]         acc_mode; // 0 overwrite, 1 add to HI/LO, 2 subtract from HI/LO

    logic               launch;
    logic               op_signed;
    logic               op_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    always_comb begin
        launch    = bus.start && !bus.req && (bus.op >= OP_MULT) && (bus.op <= OP_MSUBU);
        op_signed = bus.op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
        op_div    = bus.op inside {OP_DIV, OP_DIVU};
        a_neg     = op_signed && bus.a[WIDTH-1];
        b_neg     = op_signed && bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
    end

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge        = shifted >= {1'b0, opnd_q};
        // remainder stays below divisor, so the difference always fits in WIDTH bits
        rem_next  = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
        step_next = is_div ? {rem_next, acc_q[WIDTH-2:0], ge}
                           : {add_sum, acc_q[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] hilo_next;

    always_comb begin
        prod = neg_main ? -acc_q : acc_q;
        quot = neg_main ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (acc_mode)
            2'd1:    hilo_next = {hi_q, lo_q} + prod;
            2'd2:    hilo_next = {hi_q, lo_q} - prod;
            default: hilo_next = prod;
        endcase
        if (is_div) hilo_next = {rem, quot};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            acc_mode <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                        opnd_q   <= op_div ? abs_b : abs_a;
                        is_div   <= op_div;
                        // divide by zero yields an all-ones magnitude; flipping the sign
                        // makes a signed x/0 read as +1 for positive dividends
                        neg_main <= a_neg ^ b_neg ^ (op_signed && op_div && (bus.b == '0));
                        neg_rem  <= a_neg;
                        acc_mode <= (bus.op inside {OP_MADD, OP_MADDU}) ? 2'd1 :
                                    (bus.op inside {OP_MSUB, OP_MSUBU}) ? 2'd2 : 2'd0;
                        cnt      <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                        state    <= S_CALC;
                    end else if (!bus.req && !bus.start) begin
                        if (bus.op == OP_MTHI) hi_q <= bus.a;
                        else if (bus.op == OP_MTLO) lo_q <= bus.a;
                    end
                end
                S_CALC: begin
                    acc_q <= step_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    {hi_q, lo_q} <= hilo_next;
                    busy_q       <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.out   = (bus.op == OP_MFHI) ? hi_q : (bus.op == OP_MFLO) ? lo_q : '0;
    assign state_dbg = state;
endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter at WIDTH=32: latency, signed/unsigned mult/div, accumulate,
// req gating, commands while busy, and reset mid-operation.
module tb_md_unit_iter;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;
    int         check_cnt = 0;
    int         pass_cnt = 0;

    md_unit_iter_if #(.WIDTH(W)) bus ();

    md_unit_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req = 1'b0; bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    endtask

    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cycles);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        step();
        bus.start = 1'b0; bus.op = 4'd0;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check_cnt++; if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        check_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else pass_cnt++;
    endtask

    task automatic test_mult();
        int cyc;
        launch(4'd1, 32'hFFFF_FFFF, 32'h2, cyc);
        check_cnt++; if (cyc != 33) $display("FAIL mult_busy_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", bus.hi); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want fffffffe", bus.lo); else pass_cnt++;
        launch(4'd2, 32'hFFFF_FFFF, 32'h2, cyc);
        check_cnt++; if (cyc != 33) $display("FAIL multu_busy_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h1) $display("FAIL multu_hi: got %h want 1", bus.hi); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", bus.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int cyc;
        launch(4'd3, 32'hFFFF_FFF9, 32'h2, cyc);
        check_cnt++; if (cyc != 33) $display("FAIL div_busy_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); else pass_cnt++;
        launch(4'd4, 32'h5, 32'h0, cyc);
        check_cnt++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL divu_zero_lo: got %h want ffffffff", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h5) $display("FAIL divu_zero_hi: got %h want 5", bus.hi); else pass_cnt++;
        launch(4'd3, 32'h5, 32'h0, cyc);
        check_cnt++; if (bus.lo !== 32'h1) $display("FAIL div_zero_lo: got %h want 1", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h5) $display("FAIL div_zero_hi: got %h want 5", bus.hi); else pass_cnt++;
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check_cnt++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi: got %h want 0", bus.hi); else pass_cnt++;
        launch(4'd4, 32'd100, 32'd7, cyc);
        check_cnt++; if (bus.lo !== 32'd14) $display("FAIL divu_lo: got %0d want 14", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'd2) $display("FAIL divu_hi: got %0d want 2", bus.hi); else pass_cnt++;
    endtask

    task automatic test_mac();
        int cyc;
        bus.op = 4'd9; bus.a = 32'h55;
        step();
        bus.op = 4'd11; bus.a = 32'h0;
        #1;
        check_cnt++; if (bus.out !== 32'h55) $display("FAIL mfhi_out: got %h want 55", bus.out); else pass_cnt++;
        bus.op = 4'd10; bus.a = 32'hA;
        step();
        bus.op = 4'd9; bus.a = 32'h0;
        step();
        bus.op = 4'd12;
        #1;
        check_cnt++; if (bus.out !== 32'hA) $display("FAIL mflo_out: got %h want a", bus.out); else pass_cnt++;
        bus.op = 4'd0;
        #1;
        check_cnt++; if (bus.out !== 32'h0) $display("FAIL out_none: got %h want 0", bus.out); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h0) $display("FAIL mthi_hi: got %h want 0", bus.hi); else pass_cnt++;
        launch(4'd5, 32'h3, 32'h4, cyc);
        check_cnt++; if (bus.lo !== 32'h16) $display("FAIL madd_lo: got %h want 16", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h0) $display("FAIL madd_hi: got %h want 0", bus.hi); else pass_cnt++;
        launch(4'd8, 32'h1, 32'h17, cyc);
        check_cnt++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL msubu_lo: got %h want ffffffff", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL msubu_hi: got %h want ffffffff", bus.hi); else pass_cnt++;
        launch(4'd7, 32'hFFFF_FFFE, 32'h3, cyc);
        check_cnt++; if (bus.lo !== 32'h5) $display("FAIL msub_lo: got %h want 5", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'h0) $display("FAIL msub_hi: got %h want 0", bus.hi); else pass_cnt++;
        launch(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check_cnt++; if (bus.lo !== 32'h6) $display("FAIL maddu_lo: got %h want 6", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL maddu_hi: got %h want fffffffe", bus.hi); else pass_cnt++;
    endtask

    task automatic test_req();
        bus.req = 1'b1; bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'h3; bus.b = 32'h4;
        step();
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL req_start_busy: got %b want 0", bus.busy); else pass_cnt++;
        check_cnt++; if (state_dbg !== 2'd0) $display("FAIL req_start_state: got %0d want 0", state_dbg); else pass_cnt++;
        bus.start = 1'b0; bus.op = 4'd9; bus.a = 32'h1234;
        step();
        bus.op = 4'd10;
        step();
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL req_mthi_hi: got %h want fffffffe", bus.hi); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'h6) $display("FAIL req_mtlo_lo: got %h want 6", bus.lo); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.start = 1'b1; bus.op = 4'd4; bus.a = 32'd100; bus.b = 32'd7;
        step();
        bus.start = 1'b0; bus.op = 4'd0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                check_cnt++; if (state_dbg !== 2'd1) $display("FAIL busy_state_calc: got %0d want 1", state_dbg); else pass_cnt++;
                check_cnt++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL busy_hold_hi: got %h want fffffffe", bus.hi); else pass_cnt++;
                bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'h9; bus.b = 32'h9;
            end
            if (cyc == 6) begin bus.start = 1'b0; bus.op = 4'd9; bus.a = 32'hDEAD; end
            if (cyc == 7) begin bus.op = 4'd0; bus.a = 32'h0; end
            step();
        end
        check_cnt++; if (cyc != 33) $display("FAIL busy_ignore_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'd14) $display("FAIL busy_ignore_lo: got %h want e", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'd2) $display("FAIL busy_ignore_hi: got %h want 2", bus.hi); else pass_cnt++;
        launch(4'd2, 32'd6, 32'd7, cyc);
        check_cnt++; if (cyc != 33) $display("FAIL b2b_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'd42) $display("FAIL b2b_lo: got %0d want 42", bus.lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'h7; bus.b = 32'h6;
        step();
        bus.start = 1'b0; bus.op = 4'd0;
        for (int i = 0; i < 10; i++) step();
        check_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.busy); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'h0) $display("FAIL mid_reset_lo: got %h want 0", bus.lo); else pass_cnt++;
        check_cnt++; if (state_dbg !== 2'd0) $display("FAIL mid_reset_state: got %0d want 0", state_dbg); else pass_cnt++;
        launch(4'd1, 32'hFFFF_FFFD, 32'h5, cyc);
        check_cnt++; if (cyc != 33) $display("FAIL post_reset_cycles: got %0d want 33", cyc); else pass_cnt++;
        check_cnt++; if (bus.lo !== 32'hFFFF_FFF1) $display("FAIL post_reset_lo: got %h want fffffff1", bus.lo); else pass_cnt++;
        check_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL post_reset_hi: got %h want ffffffff", bus.hi); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_mac();
        test_req();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
